// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the reservation station.
//   OPC_RTYPE / OPC_BRANCH : opcodes whose second ALU operand is rs2 (all others use imm)
//   rs_entry_t             : layout of one station entry at the reference widths
//                            (RS_ROB_W / RS_XLEN); the RTL itself stores the same
//                            fields in per-field arrays so ROB_W/XLEN stay parameters.
//   uses_rs2()             : operand-2 source select for a given opcode
package rs_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int RS_ROB_W = 5;
  localparam int RS_XLEN  = 32;

  typedef struct packed {
    logic                busy;
    logic [6:0]          typ;
    logic [3:0]          op;
    logic [RS_ROB_W-1:0] rob_id;
    logic [RS_XLEN-1:0]  v1;
    logic [RS_XLEN-1:0]  v2;
    logic [RS_XLEN-1:0]  imm;
    logic                q1_valid;
    logic [RS_ROB_W-1:0] q1;
    logic                q2_valid;
    logic [RS_ROB_W-1:0] q2;
  } rs_entry_t;

  function automatic logic uses_rs2(input logic [6:0] typ);
    return (typ == OPC_RTYPE) || (typ == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/rs_param_station_select.sv
// rs_select: slot pickers for the reservation station.
//   busy_i     : occupied entries
//   ready_i    : entries with both operands present
//   older_i    : (RS_OLDEST_FIRST_EN only) older_i[i][j]=1 when entry i was dispatched before j
//   free_idx_o / free_vld_o : lowest-index free slot
//   iss_idx_o  / iss_vld_o  : entry to present for issue
// Macro RS_OLDEST_FIRST_EN: pick the oldest ready entry; otherwise the lowest-index one.
module rs_select
  import rs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]             busy_i,
  input  logic [DEPTH-1:0]             ready_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0]  older_i,
`endif
  output logic [$clog2(DEPTH)-1:0]     free_idx_o,
  output logic                         free_vld_o,
  output logic [$clog2(DEPTH)-1:0]     iss_idx_o,
  output logic                         iss_vld_o
);

  localparam int IW = $clog2(DEPTH);

  // Descending scans so the lowest matching index is written last.
  always_comb begin
    free_idx_o = '0;
    free_vld_o = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        free_idx_o = IW'(i);
        free_vld_o = 1'b1;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic blocked;

  // An entry wins when no other ready entry is older than it; dispatch order
  // is total, so at most one ready entry qualifies.
  always_comb begin
    iss_idx_o = '0;
    iss_vld_o = 1'b0;
    blocked   = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready_i[j] && older_i[j][i]) blocked = 1'b1;
      end
      if (ready_i[i] && !blocked) begin
        iss_idx_o = IW'(i);
        iss_vld_o = 1'b1;
      end
    end
  end
`else
  always_comb begin
    iss_idx_o = '0;
    iss_vld_o = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready_i[i]) begin
        iss_idx_o = IW'(i);
        iss_vld_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_param_station.sv
// rs_param_station: reservation station between dispatch and the ALU.
//   clk_in, rst_n_in (async, active low), rdy_in (global stall when low)
//   rs_flush_in           : synchronous clear of all entries (gated by rdy_in)
//   rs_disp_*             : dispatch request / slot-available handshake and payload
//   rs_wb_valid/rob_id/value : NUM_WB wakeup buses, port k at [k*W +: W]
//   rs_iss_*              : ready/valid issue handshake and operands
//   rs_count              : occupied entries
// Macro RS_OLDEST_FIRST_EN: keep a DEPTH x DEPTH age matrix and issue the oldest
// ready entry; when undefined the lowest-index ready entry issues.
module rs_param_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ROB_W  = 5,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      rs_flush_in,
  input  logic                      rs_disp_valid,
  output logic                      rs_disp_ready,
  input  logic [6:0]                rs_disp_type,
  input  logic [3:0]                rs_disp_op,
  input  logic [ROB_W-1:0]          rs_disp_rob_id,
  input  logic [XLEN-1:0]           rs_disp_v1,
  input  logic [XLEN-1:0]           rs_disp_v2,
  input  logic [XLEN-1:0]           rs_disp_imm,
  input  logic                      rs_disp_q1_valid,
  input  logic [ROB_W-1:0]          rs_disp_q1,
  input  logic                      rs_disp_q2_valid,
  input  logic [ROB_W-1:0]          rs_disp_q2,
  input  logic [NUM_WB-1:0]         rs_wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]   rs_wb_rob_id,
  input  logic [NUM_WB*XLEN-1:0]    rs_wb_value,
  output logic                      rs_iss_valid,
  input  logic                      rs_iss_ready,
  output logic [ROB_W-1:0]          rs_iss_rob_id,
  output logic [6:0]                rs_iss_type,
  output logic [3:0]                rs_iss_op,
  output logic [XLEN-1:0]           rs_iss_v1,
  output logic [XLEN-1:0]           rs_iss_v2,
  output logic [$clog2(DEPTH):0]    rs_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0] busy_q, q1v_q, q2v_q;
  logic [6:0]       typ_q [DEPTH];
  logic [3:0]       op_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] q1_q  [DEPTH];
  logic [ROB_W-1:0] q2_q  [DEPTH];
  logic [XLEN-1:0]  v1_q  [DEPTH];
  logic [XLEN-1:0]  v2_q  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] ready;
  logic [IW-1:0]    free_idx, iss_idx;
  logic             free_vld, iss_vld;
  logic             disp_fire, iss_fire;

  logic             byp1_hit, byp2_hit;
  logic [XLEN-1:0]  byp1_val, byp2_val;
  logic [DEPTH-1:0] wk1_hit, wk2_hit;
  logic [XLEN-1:0]  wk1_val [DEPTH];
  logic [XLEN-1:0]  wk2_val [DEPTH];

  // Readiness uses registered tags only, so a freshly written or woken entry
  // becomes visible to the picker one cycle after its write edge.
  assign ready = busy_q & ~q1v_q & ~q2v_q;

`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0] older_q;
`endif

  rs_select #(.DEPTH(DEPTH)) u_select (
    .busy_i     (busy_q),
    .ready_i    (ready),
`ifdef RS_OLDEST_FIRST_EN
    .older_i    (older_q),
`endif
    .free_idx_o (free_idx),
    .free_vld_o (free_vld),
    .iss_idx_o  (iss_idx),
    .iss_vld_o  (iss_vld)
  );

  assign rs_disp_ready = (count_q < CW'(DEPTH));
  assign disp_fire     = rs_disp_valid && rs_disp_ready && free_vld && rdy_in;
  assign iss_fire      = iss_vld && rs_iss_ready && rdy_in;

  // Ascending port loops: the highest matching port index wins.
  always_comb begin
    byp1_hit = 1'b0;
    byp2_hit = 1'b0;
    byp1_val = '0;
    byp2_val = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (rs_wb_valid[k] && rs_disp_q1_valid && rs_wb_rob_id[k*ROB_W +: ROB_W] == rs_disp_q1) begin
        byp1_hit = 1'b1;
        byp1_val = rs_wb_value[k*XLEN +: XLEN];
      end
      if (rs_wb_valid[k] && rs_disp_q2_valid && rs_wb_rob_id[k*ROB_W +: ROB_W] == rs_disp_q2) begin
        byp2_hit = 1'b1;
        byp2_val = rs_wb_value[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    wk1_hit = '0;
    wk2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1_val[i] = '0;
      wk2_val[i] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (rs_wb_valid[k] && q1v_q[i] && rs_wb_rob_id[k*ROB_W +: ROB_W] == q1_q[i]) begin
          wk1_hit[i] = 1'b1;
          wk1_val[i] = rs_wb_value[k*XLEN +: XLEN];
        end
        if (rs_wb_valid[k] && q2v_q[i] && rs_wb_rob_id[k*ROB_W +: ROB_W] == q2_q[i]) begin
          wk2_hit[i] = 1'b1;
          wk2_val[i] = rs_wb_value[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q  <= '0;
      q1v_q   <= '0;
      q2v_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ_q[i] <= '0;
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rs_flush_in) begin
        busy_q  <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_q[i] && wk1_hit[i]) begin
            v1_q[i]  <= wk1_val[i];
            q1v_q[i] <= 1'b0;
          end
          if (busy_q[i] && wk2_hit[i]) begin
            v2_q[i]  <= wk2_val[i];
            q2v_q[i] <= 1'b0;
          end
        end
        if (iss_fire) busy_q[iss_idx] <= 1'b0;
        // The dispatch slot comes from the pre-edge busy vector, so it never
        // collides with the entry issuing on this edge.
        if (disp_fire) begin
          busy_q[free_idx] <= 1'b1;
          typ_q[free_idx]  <= rs_disp_type;
          op_q[free_idx]   <= rs_disp_op;
          rob_q[free_idx]  <= rs_disp_rob_id;
          imm_q[free_idx]  <= rs_disp_imm;
          q1_q[free_idx]   <= rs_disp_q1;
          q2_q[free_idx]   <= rs_disp_q2;
          q1v_q[free_idx]  <= rs_disp_q1_valid && !byp1_hit;
          q2v_q[free_idx]  <= rs_disp_q2_valid && !byp2_hit;
          v1_q[free_idx]   <= byp1_hit ? byp1_val : rs_disp_v1;
          v2_q[free_idx]   <= byp2_hit ? byp2_val : rs_disp_v2;
        end
        count_q <= count_q + CW'(disp_fire) - CW'(iss_fire);
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // A new entry is younger than every entry currently busy; an issued entry
  // drops its row so it can no longer block anyone.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      older_q <= '0;
    end else if (rdy_in && !rs_flush_in) begin
      if (iss_fire) begin
        for (int j = 0; j < DEPTH; j++) older_q[iss_idx][j] <= 1'b0;
      end
      if (disp_fire) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_q[free_idx][j] <= 1'b0;
          older_q[j][free_idx] <= busy_q[j];
        end
      end
    end
  end
`endif

  assign rs_count      = count_q;
  assign rs_iss_valid  = iss_vld;
  assign rs_iss_rob_id = iss_vld ? rob_q[iss_idx] : '0;
  assign rs_iss_type   = iss_vld ? typ_q[iss_idx] : '0;
  assign rs_iss_op     = iss_vld ? op_q[iss_idx]  : '0;
  assign rs_iss_v1     = iss_vld ? v1_q[iss_idx]  : '0;
  assign rs_iss_v2     = !iss_vld ? '0 :
                         (uses_rs2(typ_q[iss_idx]) ? v2_q[iss_idx] : imm_q[iss_idx]);

endmodule
